intr_ctrl: RTL and testbench

Prioritized interrupt controller that sits directly upstream of the single-cycle CPU and drives its `Intr` input. It synchronizes external request lines, latches rising edges into pending bits, applies a software-written mask, selects the highest-priority source, and runs the `Intr`/`Inta` handshake. It holds the serviced source ID until the CPU signals end-of-interrupt on `eret`.

---
 rtl/intr_ctrl_pkg.sv | 21 ++
 rtl/intr_ctrl_irq_sync.sv | 38 +++
 rtl/intr_ctrl.sv | 119 +++++++++++
 tb/tb_intr_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// intr_pkg
// Shared types and constants for the prioritized interrupt controller.
//   state_t   : handshake FSM states (IDLE -> REQ -> SERV -> IDLE)
//   NSRC_DEF  : default number of interrupt sources
//   MASK_RST  : mask value after reset (all sources disabled)
// -----------------------------------------------------------------------------
package intr_pkg;

   localparam int NSRC_DEF = 8;

   // Wide enough for the largest legal NSRC; the top slices it to NSRC bits.
   localparam logic [31:0] MASK_RST = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SERV = 2'd2
   } state_t;

endpackage

// File: rtl/intr_ctrl_irq_sync.sv
// -----------------------------------------------------------------------------
// irq_sync
// One request line: two-flop synchronizer followed by a third flop used for
// rising-edge detection.
// Ports:
//   clk   in  : system clock
//   rst_n in  : asynchronous active-low reset, clears all three flops
//   irq   in  : raw asynchronous request level
//   rise  out : one-cycle pulse when the synchronized level goes 0 -> 1
// -----------------------------------------------------------------------------
module irq_sync
   import intr_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic irq,
   output logic rise
);

   logic s1_reg;
   logic s2_reg;
   logic s3_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_reg <= 1'b0;
         s2_reg <= 1'b0;
         s3_reg <= 1'b0;
      end else begin
         s1_reg <= irq;
         s2_reg <= s1_reg;
         s3_reg <= s2_reg;
      end
   end

   assign rise = s2_reg & ~s3_reg;

endmodule

// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl
// Prioritized interrupt controller feeding the CPU's Intr input. Request lines
// are synchronized, rising edges latch pending bits, a software mask gates
// arbitration (lowest index wins), and an IDLE/REQ/SERV FSM runs the
// Intr/Inta handshake and holds the serviced ID until Eoi.
// Ports:
//   Clk     in          : system clock
//   Clrn    in          : asynchronous active-low reset
//   Irq     in  [NSRC]  : raw asynchronous request levels
//   Inta    in          : CPU acknowledge pulse
//   Eoi     in          : end-of-interrupt pulse (eret)
//   Wmask   in          : mask write enable
//   MaskIn  in  [NSRC]  : new mask value, 1 = source enabled
//   Intr    out         : registered interrupt request to the CPU
//   IrqId   out [IDW]   : ID of the requested / serviced source
//   Busy    out         : serviced interrupt awaiting Eoi
//   Pend    out [NSRC]  : pending bits
//   Mask    out [NSRC]  : mask readback
// -----------------------------------------------------------------------------
module intr_ctrl
   import intr_pkg::*;
#(
   parameter int NSRC = NSRC_DEF,
   parameter int IDW  = $clog2(NSRC)
) (
   input  logic            Clk,
   input  logic            Clrn,
   input  logic [NSRC-1:0] Irq,
   input  logic            Inta,
   input  logic            Eoi,
   input  logic            Wmask,
   input  logic [NSRC-1:0] MaskIn,
   output logic            Intr,
   output logic [IDW-1:0]  IrqId,
   output logic            Busy,
   output logic [NSRC-1:0] Pend,
   output logic [NSRC-1:0] Mask
);

   state_t          state_reg;
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] elig;
   logic [NSRC-1:0] clr;
   logic [NSRC-1:0] pend_next;
   logic [IDW-1:0]  win_id;
   logic            win_valid;

   generate
      for (genvar gi = 0; gi < NSRC; gi++) begin : g_sync
         irq_sync u_sync (
            .clk   (Clk),
            .rst_n (Clrn),
            .irq   (Irq[gi]),
            .rise  (rise[gi])
         );
      end
   endgenerate

   // Priority encoder: scanning downward lets the lowest set index win.
   assign elig      = Pend & Mask;
   assign win_valid = |elig;

   always_comb begin
      win_id = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (elig[i]) win_id = IDW'(i);
      end
   end

   // Acknowledge clears the serviced bit; a same-cycle rise overrides it.
   assign clr       = (state_reg == REQ && Inta) ? (NSRC'(1) << IrqId) : '0;
   assign pend_next = (Pend & ~clr) | rise;

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         state_reg <= IDLE;
         Intr      <= 1'b0;
         Busy      <= 1'b0;
         IrqId     <= '0;
         Pend      <= '0;
         Mask      <= MASK_RST[NSRC-1:0];
      end else begin
         Pend <= pend_next;
         if (Wmask) Mask <= MaskIn;

         case (state_reg)
            IDLE: begin
               if (win_valid) begin
                  IrqId     <= win_id;
                  state_reg <= REQ;
                  Intr      <= 1'b1;
               end
            end
            // Eoi is ignored here; only Inta moves the handshake on.
            REQ: begin
               if (Inta) begin
                  state_reg <= SERV;
                  Intr      <= 1'b0;
                  Busy      <= 1'b1;
               end
            end
            // No nesting: further requests wait until Eoi returns to IDLE.
            SERV: begin
               if (Eoi) begin
                  state_reg <= IDLE;
                  Busy      <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
               Intr      <= 1'b0;
               Busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_intr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_intr_ctrl
// Directed handshake scenarios followed by randomized traffic, all checked
// against a transaction-level reference model of the interrupt controller.
// -----------------------------------------------------------------------------
module tb_intr_ctrl;

   localparam int N = 8;
   localparam int W = 3;

   logic         Clk = 1'b0;
   logic         Clrn;
   logic [N-1:0] Irq;
   logic         Inta;
   logic         Eoi;
   logic         Wmask;
   logic [N-1:0] MaskIn;
   logic         Intr;
   logic [W-1:0] IrqId;
   logic         Busy;
   logic [N-1:0] Pend;
   logic [N-1:0] Mask;

   always #5 Clk = ~Clk;

   intr_ctrl #(.NSRC(N)) dut (
      .Clk    (Clk),
      .Clrn   (Clrn),
      .Irq    (Irq),
      .Inta   (Inta),
      .Eoi    (Eoi),
      .Wmask  (Wmask),
      .MaskIn (MaskIn),
      .Intr   (Intr),
      .IrqId  (IrqId),
      .Busy   (Busy),
      .Pend   (Pend),
      .Mask   (Mask)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model. phase: 0 = nothing outstanding, 1 = request waiting for
   // ack, 2 = in service waiting for end-of-interrupt.
   int           m_phase;
   logic [N-1:0] m_pend;
   logic [N-1:0] m_mask;
   logic [W-1:0] m_id;
   logic [N-1:0] m_hist[$];   // Irq values seen at past edges, newest first

   function automatic int lowest(logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_pend  = '0;
      m_mask  = '0;
      m_id    = '0;
      m_hist.delete();
      repeat (3) m_hist.push_back('0);
   endtask

   // One clock edge. A level first seen at edge k registers as a new
   // request at edge k+2, i.e. seen two edges ago but not three edges ago.
   task automatic model_edge();
      logic [N-1:0] newreq;
      logic [N-1:0] acked;
      newreq = m_hist[1] & ~m_hist[2];
      acked  = '0;
      if (m_phase == 0) begin
         if ((m_pend & m_mask) != 0) begin
            m_id    = W'(lowest(m_pend & m_mask));
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (Inta) begin
            acked[m_id] = 1'b1;
            m_phase     = 2;
         end
      end else begin
         if (Eoi) m_phase = 0;
      end
      m_pend = (m_pend & ~acked) | newreq;
      if (Wmask) m_mask = MaskIn;
      m_hist.push_front(Irq);
      void'(m_hist.pop_back());
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("intr",  32'(Intr),  32'(m_phase == 1));
      chk("busy",  32'(Busy),  32'(m_phase == 2));
      chk("pend",  32'(Pend),  32'(m_pend));
      chk("mask",  32'(Mask),  32'(m_mask));
      chk("irqid", 32'(IrqId), 32'(m_id));
   endtask

   task automatic cycle();
      @(posedge Clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic wait_intr(int budget);
      int n = 0;
      while (Intr !== 1'b1 && n < budget) begin
         cycle();
         n++;
      end
      vectors++;
      assert (Intr === 1'b1)
      else begin
         miscompares++;
         $error("FAIL wait_intr: observed Intr %0b expected 1 within %0d cycles", Intr, budget);
      end
   endtask

   task automatic pulse_inta();
      Inta = 1'b1; cycle(); Inta = 1'b0;
   endtask

   task automatic pulse_eoi();
      Eoi = 1'b1; cycle(); Eoi = 1'b0;
   endtask

   task automatic write_mask(logic [N-1:0] v);
      Wmask = 1'b1; MaskIn = v; cycle(); Wmask = 1'b0;
   endtask

   task automatic do_reset(logic [N-1:0] irq_level);
      Irq  = irq_level;
      Clrn = 1'b0;
      model_reset();
      #1;
      check_all();
      repeat (2) @(posedge Clk);
      #1;
      check_all();
      Clrn = 1'b1;
   endtask

   initial begin
      logic [N-1:0] flip;
      Clrn = 1'b1; Irq = '0; Inta = 1'b0; Eoi = 1'b0; Wmask = 1'b0; MaskIn = '0;
      model_reset();
      #2;

      // Reset defaults, then pending bits fill while everything is masked
      do_reset(8'hFF);
      repeat (6) cycle();
      chk("pend_all_masked", 32'(Pend), 32'h0000_00FF);
      chk("no_intr_masked",  32'(Intr), 32'd0);

      // Single source full handshake with exact latency
      do_reset(8'h00);
      write_mask(8'h04);
      Irq = 8'h04;
      cycle(); cycle(); cycle();
      chk("pend2_at_k2", 32'(Pend[2]), 32'd1);
      chk("intr_at_k2",  32'(Intr),    32'd0);
      cycle();
      chk("intr_at_k3",  32'(Intr),    32'd1);
      chk("id_is_2",     32'(IrqId),   32'd2);
      pulse_inta();
      chk("pend2_acked", 32'(Pend[2]), 32'd0);
      chk("busy_acked",  32'(Busy),    32'd1);
      pulse_eoi();
      chk("busy_eoi",    32'(Busy),    32'd0);
      Irq = '0;

      // Simultaneous requests: lower index first
      write_mask(8'hFF);
      Irq = 8'h28;
      wait_intr(10);
      chk("first_id_3",  32'(IrqId), 32'd3);
      pulse_inta();
      Irq = '0;
      pulse_eoi();
      wait_intr(5);
      chk("second_id_5", 32'(IrqId), 32'd5);
      pulse_inta();
      pulse_eoi();

      // Late unmask of a request that arrived while masked
      write_mask(8'h00);
      Irq = 8'h80; cycle(); cycle(); Irq = '0;
      repeat (4) cycle();
      chk("pend7_masked", 32'(Pend[7]), 32'd1);
      chk("intr7_masked", 32'(Intr),    32'd0);
      write_mask(8'h80);
      chk("intr7_edge1",  32'(Intr),    32'd0);
      cycle();
      chk("intr7_edge2",  32'(Intr),    32'd1);
      chk("id_is_7",      32'(IrqId),   32'd7);
      pulse_inta();
      pulse_eoi();

      // Handshake corner cases
      Inta = 1'b1; cycle(); Inta = 1'b0;
      chk("inta_idle_busy", 32'(Busy), 32'd0);
      chk("inta_idle_intr", 32'(Intr), 32'd0);
      Irq = 8'h01; cycle(); cycle(); Irq = '0;
      write_mask(8'h01);
      wait_intr(10);
      Eoi = 1'b1; cycle(); Eoi = 1'b0;
      chk("eoi_in_req_intr", 32'(Intr), 32'd1);
      chk("eoi_in_req_busy", 32'(Busy), 32'd0);
      Irq = 8'h01; Eoi = 1'b1; cycle(); Eoi = 1'b0;
      cycle();
      Inta = 1'b1; Eoi = 1'b1; cycle(); Inta = 1'b0; Eoi = 1'b0;
      chk("inta_eoi_busy",  32'(Busy),    32'd1);
      chk("inta_eoi_intr",  32'(Intr),    32'd0);
      chk("set_wins_pend0", 32'(Pend[0]), 32'd1);

      // Reset while in service acts without a clock edge
      Clrn = 1'b0;
      model_reset();
      #1;
      chk("rst_mid_busy", 32'(Busy), 32'd0);
      chk("rst_mid_intr", 32'(Intr), 32'd0);
      chk("rst_mid_pend", 32'(Pend), 32'd0);
      chk("rst_mid_mask", 32'(Mask), 32'd0);
      @(posedge Clk); #1;
      check_all();
      Clrn = 1'b1;
      Irq  = '0;

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 9) == 0);
         Irq    = Irq ^ flip;
         Inta   = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         Eoi    = (m_phase == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         Wmask  = ($urandom_range(0, 19) == 0);
         MaskIn = N'($urandom);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
